// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// in_ready is registered, which cuts the combinational decode-stall path back into fetch.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no entry held; out_ir shows NOP_INSTR; in_ready=1
// FULL  | main register holds the entry presented to decode; in_ready=1
// SKID  | main and skid both hold entries; in_ready=0
module if_id_pipe_stage #(
    parameter int                  PC_WIDTH  = 16,
    parameter int                  IR_WIDTH  = 16,
    parameter logic [IR_WIDTH-1:0] NOP_INSTR = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [PC_WIDTH-1:0]  in_pc_plus,
    input  logic [IR_WIDTH-1:0]  in_ir,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [PC_WIDTH-1:0]  out_pc_plus,
    output logic [IR_WIDTH-1:0]  out_ir,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state, state_next;

    logic                in_xfer;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;
    logic [PC_WIDTH-1:0] main_pc, main_pc_plus;
    logic [IR_WIDTH-1:0] main_ir;
    logic [PC_WIDTH-1:0] skid_pc, skid_pc_plus;
    logic [IR_WIDTH-1:0] skid_ir;

    assign in_xfer = in_valid & in_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != SKID);
        end
    end

    // flush wins; entries accepted during a flush cycle are dropped without touching main
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main_in = 1'b1;
                        state_next   = FULL;
                    end
                end
                FULL: begin
                    if (out_ready && in_xfer) begin
                        load_main_in = 1'b1;
                    end else if (out_ready) begin
                        state_next = EMPTY;
                    end else if (in_xfer) begin
                        load_skid  = 1'b1;
                        state_next = SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_next     = FULL;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            main_pc      <= '0;
            main_pc_plus <= '0;
            main_ir      <= '0;
            skid_pc      <= '0;
            skid_pc_plus <= '0;
            skid_ir      <= '0;
        end else begin
            if (load_main_in) begin
                main_pc      <= in_pc;
                main_pc_plus <= in_pc_plus;
                main_ir      <= in_ir;
            end else if (load_main_skid) begin
                main_pc      <= skid_pc;
                main_pc_plus <= skid_pc_plus;
                main_ir      <= skid_ir;
            end
            if (load_skid) begin
                skid_pc      <= in_pc;
                skid_pc_plus <= in_pc_plus;
                skid_ir      <= in_ir;
            end
        end
    end

    // saturating, so a long debug stall never wraps back to a small number
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

    assign out_valid   = (state != EMPTY);
    assign out_pc      = main_pc;
    assign out_pc_plus = main_pc_plus;
    assign out_ir      = out_valid ? main_ir : NOP_INSTR;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Scoreboard bench for if_id_pipe_stage: a default 16-bit instance and a 32-bit,
// CNT_WIDTH=3 instance run side by side on the same handshake stimulus.
module tb_if_id_pipe_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp;
        logic [31:0] ir;
    } exp_t;

    logic        clock;
    logic        clear_n;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [15:0] pc16, pcp16, ir16;
    logic [31:0] pc32, pcp32, ir32;

    logic        in_ready_a, out_valid_a;
    logic [15:0] out_pc_a, out_pc_plus_a, out_ir_a, stall_a;
    logic        in_ready_b, out_valid_b;
    logic [31:0] out_pc_b, out_pc_plus_b, out_ir_b;
    logic [2:0]  stall_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] tmp16;

    assign pc32  = {16'hC0DE, pc16};
    assign pcp32 = {16'hC0DE, pcp16};
    assign ir32  = {ir16, ~ir16};

    if_id_pipe_stage dut_a (
        .clock(clock), .clear_n(clear_n),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(pc16), .in_pc_plus(pcp16), .in_ir(ir16),
        .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_pc(out_pc_a), .out_pc_plus(out_pc_plus_a), .out_ir(out_ir_a),
        .stall_count(stall_a)
    );

    if_id_pipe_stage #(
        .PC_WIDTH(32), .IR_WIDTH(32), .NOP_INSTR(32'h0000_0013), .CNT_WIDTH(3)
    ) dut_b (
        .clock(clock), .clear_n(clear_n),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(pc32), .in_pc_plus(pcp32), .in_ir(ir32),
        .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(out_pc_b), .out_pc_plus(out_pc_plus_b), .out_ir(out_ir_b),
        .stall_count(stall_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ir);
        in_valid = v;
        pc16     = pc;
        pcp16    = pc + 16'd1;
        ir16     = ir;
    endtask

    // Monitors: pop/compare on output transfers, then drop on flush or push on input transfers
    always @(negedge clock) begin
        if (!clear_n) begin
            qa.delete();
        end else begin
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected_out: got ir %h expected no entry", out_ir_a);
                end else begin
                    ea = qa.pop_front();
                    chk("a_pc", 32'(out_pc_a), ea.pc);
                    chk("a_pc_plus", 32'(out_pc_plus_a), ea.pcp);
                    chk("a_ir", 32'(out_ir_a), ea.ir);
                end
            end
            if (!out_valid_a) chk("a_nop", 32'(out_ir_a), 32'h0000_0000);
            if (flush) begin
                qa.delete();
            end else if (in_valid && in_ready_a) begin
                ea.pc  = 32'(pc16);
                ea.pcp = 32'(pcp16);
                ea.ir  = 32'(ir16);
                qa.push_back(ea);
            end
        end
    end

    always @(negedge clock) begin
        if (!clear_n) begin
            qb.delete();
        end else begin
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_out: got ir %h expected no entry", out_ir_b);
                end else begin
                    eb = qb.pop_front();
                    chk("b_pc", out_pc_b, eb.pc);
                    chk("b_pc_plus", out_pc_plus_b, eb.pcp);
                    chk("b_ir", out_ir_b, eb.ir);
                end
            end
            if (!out_valid_b) chk("b_nop", out_ir_b, 32'h0000_0013);
            if (flush) begin
                qb.delete();
            end else if (in_valid && in_ready_b) begin
                eb.pc  = pc32;
                eb.pcp = pcp32;
                eb.ir  = ir32;
                qb.push_back(eb);
            end
        end
    end

    initial begin
        clear_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        pc16      = '0;
        pcp16     = '0;
        ir16      = '0;
        #22 clear_n = 1'b1;
        tick();

        // reset state
        chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_out_ir_a", 32'(out_ir_a), 32'h0000_0000);
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_out_pc_a", 32'(out_pc_a), 32'd0);
        chk("rst_in_ready_b", 32'(in_ready_b), 32'd1);
        chk("rst_out_ir_b", out_ir_b, 32'h0000_0013);
        chk("rst_stall_b", 32'(stall_b), 32'd0);

        // streaming, one entry per cycle, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i), 16'h1001 + 16'(i));
            chk("stream_in_ready_a", 32'(in_ready_a), 32'd1);
            chk("stream_in_ready_b", 32'(in_ready_b), 32'd1);
            if (i > 0) begin
                tmp16 = 16'h1000 + 16'(i);
                chk("stream_valid_a", 32'(out_valid_a), 32'd1);
                chk("stream_latency_a", 32'(out_ir_a), 32'(tmp16));
                chk("stream_latency_b", out_ir_b, {tmp16, ~tmp16});
            end
            tick();
        end
        drive(1'b0, 16'h0, 16'h0);
        chk("stream_last_valid_a", 32'(out_valid_a), 32'd1);
        chk("stream_last_ir_a", 32'(out_ir_a), 32'h0000_1008);
        chk("stream_last_pc_a", 32'(out_pc_a), 32'd7);
        chk("stream_last_pcp_a", 32'(out_pc_plus_a), 32'd8);
        chk("stream_last_pc_b", out_pc_b, 32'hC0DE_0007);
        tick();
        chk("stream_end_valid_a", 32'(out_valid_a), 32'd0);
        chk("stream_end_stale_pc_a", 32'(out_pc_a), 32'd7);
        chk("stream_end_ir_b", out_ir_b, 32'h0000_0013);
        chk("stream_qa_empty", 32'(qa.size()), 32'd0);
        chk("stream_qb_empty", 32'(qb.size()), 32'd0);

        // skid fill and drain
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 16'hA0A0);
        tick();
        drive(1'b1, 16'h0011, 16'hB0B0);
        chk("skid_in_ready_full_a", 32'(in_ready_a), 32'd1);
        chk("skid_ir_a0_a", 32'(out_ir_a), 32'h0000_A0A0);
        tick();
        drive(1'b1, 16'h0012, 16'hDEAD);
        chk("skid_in_ready_a", 32'(in_ready_a), 32'd0);
        chk("skid_in_ready_b", 32'(in_ready_b), 32'd0);
        chk("skid_hold_ir_a", 32'(out_ir_a), 32'h0000_A0A0);
        chk("skid_hold_pc_a", 32'(out_pc_a), 32'h0000_0010);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        out_ready = 1'b1;
        chk("skid_still_blocked_a", 32'(in_ready_a), 32'd0);
        tick();
        chk("drain_ir_b0_a", 32'(out_ir_a), 32'h0000_B0B0);
        chk("drain_pc_a", 32'(out_pc_a), 32'h0000_0011);
        chk("drain_ir_b0_b", out_ir_b, 32'hB0B0_4F4F);
        chk("drain_in_ready_a", 32'(in_ready_a), 32'd1);
        tick();
        chk("drain_empty_a", 32'(out_valid_a), 32'd0);
        chk("drain_stall_a", 32'(stall_a), 32'd2);
        chk("drain_stall_b", 32'(stall_b), 32'd2);
        chk("drain_qa_empty", 32'(qa.size()), 32'd0);

        // asynchronous reset in the middle of a stalled burst
        out_ready = 1'b0;
        drive(1'b1, 16'h0020, 16'h2121);
        tick();
        drive(1'b1, 16'h0021, 16'h2222);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        #2 clear_n = 1'b0;
        #1;
        chk("arst_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("arst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("arst_out_ir_a", 32'(out_ir_a), 32'h0000_0000);
        chk("arst_out_pc_a", 32'(out_pc_a), 32'd0);
        chk("arst_stall_a", 32'(stall_a), 32'd0);
        chk("arst_out_ir_b", out_ir_b, 32'h0000_0013);
        chk("arst_out_pcp_b", out_pc_plus_b, 32'd0);
        chk("arst_stall_b", 32'(stall_b), 32'd0);
        @(negedge clock);
        #1 clear_n = 1'b1;
        tick();
        chk("arst_skid_lost_a", 32'(out_valid_a), 32'd0);

        // stall counter and saturation on the 3-bit instance
        drive(1'b1, 16'h0040, 16'h4444);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        repeat (5) tick();
        chk("stall5_a", 32'(stall_a), 32'd5);
        chk("stall5_b", 32'(stall_b), 32'd5);
        repeat (5) tick();
        chk("stall10_a", 32'(stall_a), 32'd10);
        chk("stall_sat_b", 32'(stall_b), 32'd7);
        out_ready = 1'b1;
        tick();
        chk("stall_release_valid_a", 32'(out_valid_a), 32'd0);
        chk("stall_release_a", 32'(stall_a), 32'd10);
        chk("stall_release_b", 32'(stall_b), 32'd7);

        // flush while in SKID with an in-flight entry
        out_ready = 1'b0;
        drive(1'b1, 16'h0050, 16'hD1D1);
        tick();
        drive(1'b1, 16'h0051, 16'hD2D2);
        tick();
        drive(1'b1, 16'h0052, 16'hEEEE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid_a", 32'(out_valid_a), 32'd0);
        chk("flush_valid_b", 32'(out_valid_b), 32'd0);
        chk("flush_nop_a", 32'(out_ir_a), 32'h0000_0000);
        chk("flush_nop_b", out_ir_b, 32'h0000_0013);
        chk("flush_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("flush_in_ready_b", 32'(in_ready_b), 32'd1);
        chk("flush_stale_pc_a", 32'(out_pc_a), 32'h0000_0050);
        chk("flush_qa_empty", 32'(qa.size()), 32'd0);
        drive(1'b1, 16'h0060, 16'hC0C0);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0, 16'h0);
        chk("post_flush_valid_a", 32'(out_valid_a), 32'd1);
        chk("post_flush_ir_a", 32'(out_ir_a), 32'h0000_C0C0);
        chk("post_flush_pcp_a", 32'(out_pc_plus_a), 32'h0000_0061);
        chk("post_flush_ir_b", out_ir_b, 32'hC0C0_3F3F);
        tick();
        chk("post_flush_empty_a", 32'(out_valid_a), 32'd0);

        // flush in FULL with simultaneous output and input transfers
        drive(1'b1, 16'h0070, 16'h7777);
        tick();
        drive(1'b1, 16'h0071, 16'h8888);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk("flush_full_valid_a", 32'(out_valid_a), 32'd0);
        chk("flush_full_pc_a", 32'(out_pc_a), 32'h0000_0070);
        chk("flush_full_pc_b", out_pc_b, 32'hC0DE_0070);
        chk("flush_full_in_ready_a", 32'(in_ready_a), 32'd1);
        tick();
        chk("flush_full_dropped_a", 32'(out_valid_a), 32'd0);
        chk("flush_full_dropped_b", 32'(out_valid_b), 32'd0);

        // bounded final drain
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (qa.size() == 0 && qb.size() == 0 && !out_valid_a && !out_valid_b) break;
            tick();
        end
        chk("final_qa_empty", 32'(qa.size()), 32'd0);
        chk("final_qb_empty", 32'(qb.size()), 32'd0);
        chk("final_valid_a", 32'(out_valid_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
